// File: rtl/nibble_serial_addsub_pkg.sv
// nibble_serial_addsub_pkg: state encodings and nibble width shared by the serial adder/subtractor.
package nibble_serial_addsub_pkg;
    localparam int NIB_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/nibble_serial_addsub_cla4.sv
// cla4: 4-bit carry-lookahead adder, one nibble of the serial datapath.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] sum,
    output logic       c4
);
    logic [3:0] g, p;
    logic [3:1] c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);
    assign sum = p ^ {c, c0};
endmodule

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: WIDTH-bit add/sub, one CLA4 nibble per clock, LSB nibble first.
// Define NIBSER_FLAGS_EN to add registered ovf/zero flags.
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef NIBSER_FLAGS_EN
    output logic             ovf,
    output logic             zero,
`endif
    output logic             cout
);
    localparam int NIB = WIDTH / NIB_W;
    localparam int CW = $clog2(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic carry, c4;
    logic [WIDTH-1:0] a_r, b_r;
    logic [NIB_W-1:0] sum;

    cla4 u_cla4 (
        .a  (a_r[cnt*NIB_W +: NIB_W]),
        .b  (b_r[cnt*NIB_W +: NIB_W]),
        .c0 (carry),
        .sum(sum),
        .c4 (c4)
    );

    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = in_valid ? RUN : IDLE;
            RUN: state_n = cnt == LAST ? DONE : RUN;
            DONE: state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // b is stored already inverted for subtract; carry-in of 1 completes the two's complement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            carry <= 1'b0;
            a_r <= '0;
            b_r <= '0;
            result <= '0;
            cout <= 1'b0;
`ifdef NIBSER_FLAGS_EN
            ovf <= 1'b0;
            zero <= 1'b0;
`endif
        end else if (state == IDLE && in_valid) begin
            a_r <= a;
            b_r <= op_sub ? ~b : b;
            carry <= op_sub | cin;
            cnt <= '0;
        end else if (state == RUN) begin
            result[cnt*NIB_W +: NIB_W] <= sum;
            carry <= c4;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                cout <= c4;
`ifdef NIBSER_FLAGS_EN
                // top nibble is being written this edge, so use sum directly
                ovf <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[NIB_W-1] != a_r[WIDTH-1]);
                zero <= (result[WIDTH-NIB_W-1:0] == '0) && (sum == '0);
`endif
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// tb_nibble_serial_addsub: directed vectors for nibble_serial_addsub (flags checked when NIBSER_FLAGS_EN).
module tb_nibble_serial_addsub;
    logic clk = 0, rst = 1;
    logic in_valid = 0, op_sub = 0, cin = 0, out_ready = 0;
    logic [15:0] a = 0, b = 0;
    logic in_ready, out_valid, cout;
    logic [15:0] result;
`ifdef NIBSER_FLAGS_EN
    logic ovf, zero;
`endif
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    nibble_serial_addsub #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
`ifdef NIBSER_FLAGS_EN
        .ovf(ovf), .zero(zero),
`endif
        .cout(cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic sub, input logic ci);
        @(negedge clk);
        a = av; b = bv; op_sub = sub; cin = ci; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        a = 16'hDEAD; b = 16'hBEEF; op_sub = ~sub; cin = ~ci;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        check({tag, " latency"}, cyc, 4);
    endtask

    task automatic retire();
        @(negedge clk) out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        check("retire in_ready", in_ready, 1);
        check("retire out_valid", out_valid, 0);
    endtask

    task automatic op(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic sub,
                      input logic ci, input logic [15:0] er, input logic ec, input logic eo, input logic ez);
        issue(av, bv, sub, ci);
        wait_done(tag);
        check({tag, " result"}, result, er);
        check({tag, " cout"}, cout, ec);
`ifdef NIBSER_FLAGS_EN
        check({tag, " ovf"}, ovf, eo);
        check({tag, " zero"}, zero, ez);
`else
        if (eo && ez) checks += 0;
`endif
        retire();
    endtask

    initial begin
        #12;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset cout", cout, 0);
        @(negedge clk) rst = 0;

        op("add1", 16'h1234, 16'h0FFF, 0, 0, 16'h2233, 0, 0, 0);
        op("ripple", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
        op("sub", 16'h0005, 16'h0007, 1, 0, 16'hFFFE, 0, 0, 0);
        op("ovf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
        op("cin", 16'h00FF, 16'h0000, 0, 1, 16'h0100, 0, 0, 0);
        op("subeq", 16'h8000, 16'h8000, 1, 1, 16'h0000, 1, 0, 1);

        issue(16'h0F0F, 16'h0101, 0, 0);
        wait_done("bp");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'h1111; b = 16'h2222; in_valid = 1;
            @(posedge clk);
            #1;
            check("bp result", result, 16'h1010);
            check("bp cout", cout, 0);
            check("bp out_valid", out_valid, 1);
            check("bp in_ready", in_ready, 0);
        end
        @(negedge clk) in_valid = 0;
        retire();

        issue(16'hAAAA, 16'h5555, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1;
        #1;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst result", result, 0);
        @(negedge clk) rst = 0;
        op("after rst", 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle WIDTH-bit adder/subtractor for the machine CPU datapath.
- Drives one CLA4 instance one nibble per clock, least significant nibble first, and registers the carry between nibbles.
- Sits directly upstream of CLA4, supplying its a, b and c0 inputs, and consumes its sum and c4 outputs.
- Valid/ready handshake on both sides so the control unit can issue operations and stall on results.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4 (derived, not overridable), number of nibble steps per operation.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept an operation.
- op_sub  in  1  0 = a+b+cin, 1 = a-b (cin ignored).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference.
- cout  out  1  final carry out of the MSB nibble; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow (only with NIBSER_FLAGS_EN).
- zero  out  1  result == 0 (only with NIBSER_FLAGS_EN).

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; in_ready=1; out_valid=0; result=0; cout=0; ovf=0; zero=0.
  - Nibble counter=0 and carry register=0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, DONE (encodings in shared header).
- in_ready is 1 only in IDLE; out_valid is 1 only in DONE. Both are pure decodes of registered state.
- IDLE:
  - On in_valid&in_ready at edge T, latch a, b' and op_sub, where b' = op_sub ? ~b : b.
  - Carry register := op_sub ? 1 : cin; counter := 0; go to RUN.
- RUN, each edge:
  - CLA4 is fed a'[4k+3:4k], b'[4k+3:4k] and the carry register (k = counter).
  - sum nibble is written to result[4k+3:4k]; carry register := c4; counter++.
  - After nibble NIB-1 (edge T+NIB), go to DONE.
  - cout := final c4.
- Latency: out_valid is high from edge T+NIB. For WIDTH=16 that is 4 cycles after the acceptance edge.
- DONE:
  - result/cout/flags are held stable while out_ready=0, for any number of cycles.
  - On out_ready=1, return to IDLE at that edge.
  - A new operation may be accepted no earlier than the following edge.
- result is undefined-to-consumer outside DONE but must not glitch to X. Unprocessed nibbles keep their previous values.
- in_valid while not in IDLE is ignored; operands must not be sampled.
- a/b/op_sub changes after acceptance have no effect on the running operation.

Optional Feature:
- Macro: NIBSER_FLAGS_EN.
- Defined: ports ovf and zero exist, registered and valid with out_valid.
  - ovf = (a[W-1] == b'[W-1]) && (result[W-1] != a[W-1]).
  - zero = (result == 0).
  - Both are computed at the transition into DONE.
- Undefined: ovf/zero ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared header nibser_defs.v, include-guarded, holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the nibble width constant 4.
- One sub-module: the existing CLA4, instantiated once. No other sub-module.
- Control FSM, counter and operand/result registers stay in nibble_serial_addsub.

Test Plan:
1. a=16'h1234, b=16'h0FFF, op_sub=0, cin=0 → after 4 cycles out_valid=1, result=16'h2233, cout=0, ovf=0, zero=0.
2. a=16'hFFFF, b=16'h0001, op_sub=0, cin=0 → result=16'h0000, cout=1, zero=1, ovf=0. Carry ripples through all four nibble steps.
3. a=16'h0005, b=16'h0007, op_sub=1 → result=16'hFFFE, cout=0 (borrow), ovf=0. Also a=16'h7FFF, b=16'h0001, add → result=16'h8000, ovf=1.
4. Backpressure: out_ready=0 for 3 cycles in DONE → result, cout and out_valid stable; in_ready=0.
   - Pulsing in_valid with new operands during this window is ignored.
   - Raise out_ready → IDLE next edge.
5. Reset mid-run: assert rst 2 cycles after acceptance → in_ready=1, out_valid=0, result=0 immediately.
   - The next operation, 16'h0001+16'h0001, yields 16'h0002.
6. Build without NIBSER_FLAGS_EN and rerun scenarios 1–3 → identical result and cout; ovf and zero ports absent.
